tag_arb_cmp: RTL and testbench

Parametrised successor of the data-cache tag-compare stage. It arbitrates `NR_PORTS` requesters onto one shared tag/data SRAM port. Arbitration is fixed-priority or round-robin, and a granted port can lock the arbiter for back-to-back accesses. One cycle after each grant it compares the late-arriving tag of the granted port against every way, and flags multi-way hits. It sits between the cache controller ports (miss handler, load, store) and the SRAM array wrapper.

---
 rtl/tag_arb_cmp_if.sv | 50 +++++
 rtl/tag_arb_cmp.sv | 127 ++++++++++++
 tb/tb_tag_arb_cmp.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tag_arb_cmp_if.sv
// Request/SRAM/compare bundle for tag_arb_cmp; per-port fields are flattened, port k at slice k.
interface tag_arb_cmp_if #(
    parameter int unsigned NR_PORTS   = 3,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned SET_ASSOC  = 8,
    parameter int unsigned TAG_WIDTH  = 44,
    parameter int unsigned LINE_WIDTH = 128
);
    localparam int unsigned BE_WIDTH = LINE_WIDTH / 8;
    localparam int unsigned ID_WIDTH = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

    logic [NR_PORTS-1:0]            req_i;
    logic [NR_PORTS*SET_ASSOC-1:0]  way_i;
    logic [NR_PORTS-1:0]            lock_i;
    logic [NR_PORTS-1:0]            gnt_o;
    logic [NR_PORTS*ADDR_WIDTH-1:0] addr_i;
    logic [NR_PORTS-1:0]            we_i;
    logic [NR_PORTS*BE_WIDTH-1:0]   be_i;
    logic [NR_PORTS*LINE_WIDTH-1:0] wdata_i;
    logic [NR_PORTS*TAG_WIDTH-1:0]  tag_i;

    logic [SET_ASSOC-1:0]            req_o;
    logic [ADDR_WIDTH-1:0]           addr_o;
    logic                            we_o;
    logic [BE_WIDTH-1:0]             be_o;
    logic [LINE_WIDTH-1:0]           wdata_o;
    logic [SET_ASSOC*TAG_WIDTH-1:0]  rtag_i;
    logic [SET_ASSOC-1:0]            rvalid_i;
    logic [SET_ASSOC*LINE_WIDTH-1:0] rdata_i;
    logic [SET_ASSOC*LINE_WIDTH-1:0] rdata_o;

    logic [SET_ASSOC-1:0] hit_way_o;
    logic                 hit_valid_o;
    logic [ID_WIDTH-1:0]  hit_port_o;
    logic                 multi_hit_o;

    modport master (
        output req_i, way_i, lock_i, addr_i, we_i, be_i, wdata_i, tag_i,
               rtag_i, rvalid_i, rdata_i,
        input  gnt_o, req_o, addr_o, we_o, be_o, wdata_o, rdata_o,
               hit_way_o, hit_valid_o, hit_port_o, multi_hit_o
    );

    modport slave (
        input  req_i, way_i, lock_i, addr_i, we_i, be_i, wdata_i, tag_i,
               rtag_i, rvalid_i, rdata_i,
        output gnt_o, req_o, addr_o, we_o, be_o, wdata_o, rdata_o,
               hit_way_o, hit_valid_o, hit_port_o, multi_hit_o
    );
endinterface

// File: rtl/tag_arb_cmp.sv
// Arbitrates NR_PORTS requesters onto one tag/data SRAM port, then compares the late tag against all ways.
// Define TAG_ARB_CMP_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module tag_arb_cmp #(
    parameter int unsigned NR_PORTS   = 3,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned SET_ASSOC  = 8,
    parameter int unsigned TAG_WIDTH  = 44,
    parameter int unsigned LINE_WIDTH = 128
) (
    input  logic         clk_i,
    input  logic         rst_i,
    tag_arb_cmp_if.slave bus
);
    localparam int unsigned BE_WIDTH = LINE_WIDTH / 8;
    localparam int unsigned ID_WIDTH = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

    logic [ID_WIDTH-1:0]  id_q;
    logic                 lock_q;
    logic                 cmp_vld_q;
    logic                 multi_hit_q;
    logic [ID_WIDTH-1:0]  win;
    logic                 lock_win;
    logic                 any_req;
    logic [TAG_WIDTH-1:0] cmp_tag;
    logic [SET_ASSOC-1:0] hit_way;

`ifdef TAG_ARB_CMP_RR_EN
    logic [ID_WIDTH-1:0] rr_q;
    logic                found;
    int unsigned         rr_idx;
`endif

    assign any_req = |bus.req_i;

    // Winner selection: a held lock beats the policy.
    always_comb begin
        lock_win = lock_q && bus.req_i[id_q];
        win      = '0;
`ifdef TAG_ARB_CMP_RR_EN
        found    = 1'b0;
        rr_idx   = 0;
`endif
        if (lock_win) begin
            win = id_q;
        end else begin
`ifdef TAG_ARB_CMP_RR_EN
            for (int unsigned i = 0; i < NR_PORTS; i++) begin
                rr_idx = (32'(rr_q) + i) % NR_PORTS;
                if (!found && bus.req_i[ID_WIDTH'(rr_idx)]) begin
                    win   = ID_WIDTH'(rr_idx);
                    found = 1'b1;
                end
            end
`else
            for (int i = int'(NR_PORTS) - 1; i >= 0; i--) begin
                if (bus.req_i[ID_WIDTH'(i)]) win = ID_WIDTH'(i);
            end
`endif
        end
    end

    // SRAM command mux; everything idles to zero with no requester.
    always_comb begin
        bus.gnt_o   = '0;
        bus.req_o   = '0;
        bus.addr_o  = '0;
        bus.we_o    = 1'b0;
        bus.be_o    = '0;
        bus.wdata_o = '0;
        if (any_req) begin
            bus.gnt_o[win] = 1'b1;
            bus.req_o      = bus.way_i[32'(win)*SET_ASSOC +: SET_ASSOC];
            bus.addr_o     = bus.addr_i[32'(win)*ADDR_WIDTH +: ADDR_WIDTH];
            bus.we_o       = bus.we_i[win];
            bus.be_o       = bus.be_i[32'(win)*BE_WIDTH +: BE_WIDTH];
            bus.wdata_o    = bus.wdata_i[32'(win)*LINE_WIDTH +: LINE_WIDTH];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            id_q      <= '0;
            lock_q    <= 1'b0;
            cmp_vld_q <= 1'b0;
        end else if (any_req) begin
            id_q      <= win;
            lock_q    <= bus.lock_i[win];
            cmp_vld_q <= 1'b1;
        end else begin
            lock_q    <= 1'b0;
            cmp_vld_q <= 1'b0;
        end
    end

`ifdef TAG_ARB_CMP_RR_EN
    // Pointer skips past the winner, but a locked re-grant does not advance it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q <= '0;
        end else if (any_req && !lock_win) begin
            rr_q <= (win == ID_WIDTH'(NR_PORTS - 1)) ? '0 : win + 1'b1;
        end
    end
`endif

    assign cmp_tag = bus.tag_i[32'(id_q)*TAG_WIDTH +: TAG_WIDTH];

    for (genvar j = 0; j < int'(SET_ASSOC); j++) begin : g_way
        assign hit_way[j] = cmp_vld_q && bus.rvalid_i[j] &&
                            (bus.rtag_i[j*TAG_WIDTH +: TAG_WIDTH] == cmp_tag);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            multi_hit_q <= 1'b0;
        end else if ($countones(hit_way) > 1) begin
            multi_hit_q <= 1'b1;
        end
    end

    assign bus.hit_way_o   = hit_way;
    assign bus.hit_valid_o = cmp_vld_q;
    assign bus.hit_port_o  = id_q;
    assign bus.multi_hit_o = multi_hit_q;
    assign bus.rdata_o     = bus.rdata_i;

endmodule

// File: tb/tb_tag_arb_cmp.sv
// Self-checking bench for tag_arb_cmp: directed scenarios plus random traffic against a per-cycle reference model.
module tb_tag_arb_cmp;
    localparam int NP = 3;
    localparam int NW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tag_arb_cmp_if #(.NR_PORTS(3), .ADDR_WIDTH(64), .SET_ASSOC(8), .TAG_WIDTH(44), .LINE_WIDTH(128)) bus ();

    tag_arb_cmp #(.NR_PORTS(3), .ADDR_WIDTH(64), .SET_ASSOC(8), .TAG_WIDTH(44), .LINE_WIDTH(128)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    // stimulus, one entry per port / per way
    logic [2:0]   t_req, t_lock, t_we;
    logic [7:0]   t_way   [NP];
    logic [63:0]  t_addr  [NP];
    logic [15:0]  t_be    [NP];
    logic [127:0] t_wdata [NP];
    logic [43:0]  t_tag   [NP];
    logic [43:0]  t_rtag  [NW];
    logic [7:0]   t_rvalid;
    logic [127:0] t_rdata [NW];

    // reference model state
    int m_id, m_rr;
    bit m_lock, m_vld, m_multi;
    int cur_w;
    bit cur_lockwin;
    int cur_pop;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_id = 0; m_rr = 0; m_lock = 0; m_vld = 0; m_multi = 0;
    endtask

    task automatic clear_inputs();
        t_req = '0; t_lock = '0; t_we = '0; t_rvalid = '0;
        for (int p = 0; p < NP; p++) begin
            t_way[p] = '0; t_addr[p] = '0; t_be[p] = '0; t_wdata[p] = '0; t_tag[p] = '0;
        end
        for (int j = 0; j < NW; j++) begin
            t_rtag[j] = '0; t_rdata[j] = '0;
        end
    endtask

    task automatic randomize_inputs();
        t_req = 3'($urandom); t_lock = 3'($urandom); t_we = 3'($urandom);
        t_rvalid = 8'($urandom);
        for (int p = 0; p < NP; p++) begin
            t_way[p]   = 8'($urandom);
            t_addr[p]  = {$urandom, $urandom};
            t_be[p]    = 16'($urandom);
            t_wdata[p] = {$urandom, $urandom, $urandom, $urandom};
            t_tag[p]   = 44'($urandom_range(0, 3));
        end
        for (int j = 0; j < NW; j++) begin
            t_rtag[j]  = 44'($urandom_range(0, 3));
            t_rdata[j] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic apply();
        bus.req_i = t_req; bus.lock_i = t_lock; bus.we_i = t_we; bus.rvalid_i = t_rvalid;
        for (int p = 0; p < NP; p++) begin
            bus.way_i[p*8 +: 8]       = t_way[p];
            bus.addr_i[p*64 +: 64]    = t_addr[p];
            bus.be_i[p*16 +: 16]      = t_be[p];
            bus.wdata_i[p*128 +: 128] = t_wdata[p];
            bus.tag_i[p*44 +: 44]     = t_tag[p];
        end
        for (int j = 0; j < NW; j++) begin
            bus.rtag_i[j*44 +: 44]    = t_rtag[j];
            bus.rdata_i[j*128 +: 128] = t_rdata[j];
        end
    endtask

    function automatic int policy_pick(input logic [2:0] req, input int rr);
`ifdef TAG_ARB_CMP_RR_EN
        for (int o = 0; o < NP; o++) begin
            if (req[(rr + o) % NP]) return (rr + o) % NP;
        end
`else
        for (int p = 0; p < NP; p++) begin
            if (req[p]) return p;
        end
`endif
        return -1;
    endfunction

    // Compare every output against what the model expects for the current inputs.
    task automatic check_outputs();
        logic [2:0]    e_gnt;
        logic [7:0]    e_req, e_hit;
        logic [63:0]   e_addr;
        logic          e_we;
        logic [15:0]   e_be;
        logic [127:0]  e_wdata;
        logic [1023:0] e_rdata;
        cur_w = -1; cur_lockwin = 0;
        if (t_req != 0) begin
            if (m_lock && t_req[m_id]) begin
                cur_w = m_id; cur_lockwin = 1;
            end else begin
                cur_w = policy_pick(t_req, m_rr);
            end
        end
        e_gnt = '0; e_req = '0; e_addr = '0; e_we = 0; e_be = '0; e_wdata = '0;
        if (cur_w >= 0) begin
            e_gnt[cur_w] = 1'b1;
            e_req = t_way[cur_w]; e_addr = t_addr[cur_w]; e_we = t_we[cur_w];
            e_be = t_be[cur_w]; e_wdata = t_wdata[cur_w];
        end
        for (int j = 0; j < NW; j++) begin
            e_hit[j] = m_vld && t_rvalid[j] && (t_rtag[j] == t_tag[m_id]);
            e_rdata[j*128 +: 128] = t_rdata[j];
        end
        cur_pop = $countones(e_hit);
        check("gnt", 1024'(bus.gnt_o), 1024'(e_gnt));
        check("req_o", 1024'(bus.req_o), 1024'(e_req));
        check("addr_o", 1024'(bus.addr_o), 1024'(e_addr));
        check("we_o", 1024'(bus.we_o), 1024'(e_we));
        check("be_o", 1024'(bus.be_o), 1024'(e_be));
        check("wdata_o", 1024'(bus.wdata_o), 1024'(e_wdata));
        check("rdata_o", bus.rdata_o, e_rdata);
        check("hit_valid", 1024'(bus.hit_valid_o), 1024'(m_vld));
        check("hit_port", 1024'(bus.hit_port_o), 1024'(m_id));
        check("hit_way", 1024'(bus.hit_way_o), 1024'(e_hit));
        check("multi_hit", 1024'(bus.multi_hit_o), 1024'(m_multi));
    endtask

    task automatic eval();
        apply();
        #1;
        check_outputs();
    endtask

    // Advance one clock and let the model take the same step.
    task automatic step();
        @(posedge clk);
        if (cur_w >= 0) begin
            if (!cur_lockwin) m_rr = (cur_w + 1) % NP;
            m_id = cur_w; m_lock = t_lock[cur_w]; m_vld = 1;
        end else begin
            m_vld = 0; m_lock = 0;
        end
        if (cur_pop > 1) m_multi = 1;
        #1;
    endtask

    logic [2:0] exp_seq [4];

    initial begin
        model_reset();
        clear_inputs();
        apply();
        #3;
        eval();
        check("rst_hit_valid", 1024'(bus.hit_valid_o), 1024'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // all three request for 4 cycles
`ifdef TAG_ARB_CMP_RR_EN
        exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100; exp_seq[3] = 3'b001;
`else
        exp_seq[0] = 3'b001; exp_seq[1] = 3'b001; exp_seq[2] = 3'b001; exp_seq[3] = 3'b001;
`endif
        for (int c = 0; c < 4; c++) begin
            t_req = 3'b111;
            eval();
            check("simul_gnt", 1024'(bus.gnt_o), 1024'(exp_seq[c]));
            step();
        end

        // port 2 takes the arbiter, then holds it with lock while all request
        t_req = 3'b100; t_lock = 3'b100;
        eval();
        step();
        for (int c = 0; c < 3; c++) begin
            t_req = 3'b111; t_lock = 3'b100;
            eval();
            check("lock_gnt", 1024'(bus.gnt_o), 1024'(3'b100));
            step();
        end
        t_lock = 3'b000; t_req = 3'b111;
        eval();
        step();

        // single hit on way 5 for port 1
        clear_inputs();
        t_req = 3'b010; t_way[1] = 8'hFF;
        eval();
        check("single_req_o", 1024'(bus.req_o), 1024'(8'hFF));
        step();
        clear_inputs();
        t_tag[1] = 44'h123; t_rtag[5] = 44'h123; t_rvalid = 8'h20;
        eval();
        check("single_hit_way", 1024'(bus.hit_way_o), 1024'(8'h20));
        check("single_hit_port", 1024'(bus.hit_port_o), 1024'(1));
        check("single_hit_valid", 1024'(bus.hit_valid_o), 1024'(1));
        step();

        // invalid way 3 ignored; ways 0 and 4 both hit
        clear_inputs();
        t_req = 3'b001; t_way[0] = 8'h01;
        eval();
        step();
        clear_inputs();
        t_tag[0] = 44'h55; t_rtag[0] = 44'h55; t_rtag[3] = 44'h55; t_rtag[4] = 44'h55;
        t_rtag[1] = 44'h56; t_rvalid = 8'h17;
        eval();
        check("multi_hit_way", 1024'(bus.hit_way_o), 1024'(8'h11));
        step();

        // idle: nothing granted and the compare stage empties a cycle later
        clear_inputs();
        eval();
        check("multi_sticky", 1024'(bus.multi_hit_o), 1024'(1));
        check("idle_gnt", 1024'(bus.gnt_o), 1024'(0));
        check("idle_req_o", 1024'(bus.req_o), 1024'(0));
        step();
        eval();
        check("idle_hit_valid", 1024'(bus.hit_valid_o), 1024'(0));
        check("multi_still_set", 1024'(bus.multi_hit_o), 1024'(1));
        step();

        // random traffic
        for (int c = 0; c < 400; c++) begin
            randomize_inputs();
            eval();
            step();
        end

        // async reset in the middle of a compare
        clear_inputs();
        t_req = 3'b001; t_way[0] = 8'hFF;
        eval();
        step();
        clear_inputs();
        t_tag[0] = 44'h9; t_rtag[2] = 44'h9; t_rtag[6] = 44'h9; t_rvalid = 8'h44;
        apply();
        #1;
        check("pre_rst_hit_valid", 1024'(bus.hit_valid_o), 1024'(1));
        rst = 1'b1;
        #1;
        check("async_hit_valid", 1024'(bus.hit_valid_o), 1024'(0));
        check("async_hit_way", 1024'(bus.hit_way_o), 1024'(0));
        check("async_multi", 1024'(bus.multi_hit_o), 1024'(0));
        check("async_hit_port", 1024'(bus.hit_port_o), 1024'(0));
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 100; c++) begin
            randomize_inputs();
            eval();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
